// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-side handshake between the TX fifo and the UART transmitter.
// The transmitter (master) pops words with rd; the fifo (slave) reports
// its head word and empty flag.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  rd;

    modport master (
        output rd,
        input  empty,
        input  r_data
    );

    modport slave (
        input  rd,
        output empty,
        output r_data
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining the TX fifo: pops one word per frame and sends
// it LSB-first as start / data / stop, with its own baud tick generator.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    uart_tx_fifo_drain_if.master  fifo,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int S_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  state_q, state_n;
    logic [DVSR_WIDTH-1:0]   b_q, b_n;
    logic [DVSR_WIDTH-1:0]   dvsr_q, dvsr_n;
    logic [S_W-1:0]          s_q, s_n;
    logic [N_W-1:0]          n_q, n_n;
    logic [DATA_WIDTH-1:0]   sh_q, sh_n;
    logic                    rd_c;
    logic                    tick;
`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_n;
`endif

    assign tick = (b_q == dvsr_q);

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            b_q     <= '0;
            dvsr_q  <= '0;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            b_q     <= b_n;
            dvsr_q  <= dvsr_n;
            s_q     <= s_n;
            n_q     <= n_n;
            sh_q    <= sh_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // Next-state, baud counter, tick/bit counters, shift register and pop strobe.
    always_comb begin
        state_n = state_q;
        dvsr_n  = dvsr_q;
        s_n     = s_q;
        n_n     = n_q;
        sh_n    = sh_q;
        rd_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        if (state_q == IDLE || tick) begin
            b_n = '0;
        end else begin
            b_n = b_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tx_en && !fifo.empty) begin
                    rd_c    = 1'b1;
                    sh_n    = fifo.r_data;
                    s_n     = '0;
                    n_n     = '0;
                    dvsr_n  = dvsr;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^fifo.r_data;
`endif
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_n     = '0;
                        state_n = DATA;
                    end else begin
                        s_n = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_n  = '0;
                        sh_n = sh_q >> 1;
                        if (n_q == N_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_n = n_q + 1'b1;
                        end
                    end else begin
                        s_n = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        s_n     = '0;
                        state_n = IDLE;
                    end else begin
                        s_n = s_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Serial line level decoded from registered state only (no path from empty).
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = sh_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = par_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    // The pop strobe is qualified by reset so it drops as soon as reset asserts.
    assign fifo.rd = rd_c & reset;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: a queue models the TX fifo and
// each scenario task drives stimulus and checks the captured line levels.
module tb_uart_tx_fifo_drain;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_en;
    logic [10:0] dvsr;
    logic        tx;
    logic        tx_busy;

    uart_tx_fifo_drain_if #(.DATA_WIDTH(DW)) fifo_if ();

    uart_tx_fifo_drain #(
        .DATA_WIDTH(DW),
        .SB_TICK(16),
        .DVSR_WIDTH(11)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_en(tx_en),
        .dvsr(dvsr),
        .fifo(fifo_if),
        .tx(tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic cap_tx[$];
    logic cap_rd[$];
    logic cap_busy[$];

    task automatic refresh();
        fifo_if.empty  = (fq.size() == 0);
        fifo_if.r_data = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] d);
        fq.push_back(d);
        refresh();
    endtask

    // Fifo model: a pop seen mid-cycle takes effect at the following edge.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_if.rd === 1'b1) begin
                @(posedge clk);
                #1;
                if (fq.size() > 0) fq.delete(0);
                refresh();
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_cap();
        cap_tx.delete();
        cap_rd.delete();
        cap_busy.delete();
    endtask

    task automatic capture(input int n);
        repeat (n) begin
            @(negedge clk);
            cap_tx.push_back(tx);
            cap_rd.push_back(fifo_if.rd);
            cap_busy.push_back(tx_busy);
        end
    endtask

    task automatic wait_rd(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (fifo_if.rd === 1'b1) found = 1'b1;
        end
    endtask

    // Expected line level c clocks after the pop cycle, b clocks per bit.
    function automatic logic frame_level(input logic [7:0] d, input int c, input int b);
        int idx;
        if (c < 1) return 1'b1;
        idx = (c - 1) / b;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tx_en = 1'b1;
        dvsr  = '0;
        refresh();
        #12;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        push(8'h11);
        #1;
        checks++;
        if (fifo_if.rd !== 1'b0) begin errors++; $display("FAIL reset_rd_held: got %b expected 0", fifo_if.rd); end
        fq.delete();
        refresh();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_after_release: got busy=%b tx=%b expected busy=0 tx=1", tx_busy, tx);
        end
    endtask

    task automatic test_single_frame();
        int nf, mism, busy, rdc;
        bit found;
        nf = NBITS * 16;
        dvsr  = 11'd0;
        tx_en = 1'b1;
        @(posedge clk);
        #1;
        push(8'hA5);
        wait_rd(20, found);
        checks++;
        if (!found) begin errors++; $display("FAIL single_rd_seen: got 0 expected 1"); end
        clear_cap();
        capture(nf + 1);
        mism = 0; busy = 0; rdc = 0;
        for (int i = 0; i <= nf; i++) begin
            if (cap_tx[i] !== frame_level(8'hA5, i + 1, 16)) mism++;
            if (cap_busy[i] === 1'b1) busy++;
            if (cap_rd[i] !== 1'b0) rdc++;
        end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL single_tx_pattern: got %0d bad clocks expected 0", mism); end
        checks++;
        if (busy != nf) begin errors++; $display("FAIL single_busy_len: got %0d expected %0d", busy, nf); end
        checks++;
        if (rdc != 0) begin errors++; $display("FAIL single_rd_width: got %0d extra rd clocks expected 0", rdc); end
        checks++;
        if (cap_busy[nf] !== 1'b0 || fq.size() != 0) begin
            errors++;
            $display("FAIL single_end_idle: got busy=%b fifo=%0d expected busy=0 fifo=0", cap_busy[nf], fq.size());
        end
    endtask

    task automatic test_back_to_back();
        int nf, mism, rdc;
        bit found;
        nf = NBITS * 64;
        dvsr = 11'd3;
        @(posedge clk);
        #1;
        push(8'h00);
        push(8'hFF);
        wait_rd(20, found);
        checks++;
        if (!found) begin errors++; $display("FAIL b2b_rd_seen: got 0 expected 1"); end
        clear_cap();
        capture(2 * nf + 2);
        mism = 0; rdc = 0;
        for (int c = 1; c <= 2 * nf + 2; c++) begin
            logic e;
            if (c <= nf) e = frame_level(8'h00, c, 64);
            else if (c == nf + 1) e = 1'b1;
            else e = frame_level(8'hFF, c - nf - 1, 64);
            if (cap_tx[c-1] !== e) mism++;
            if (cap_rd[c-1] === 1'b1) rdc++;
        end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL b2b_tx_pattern: got %0d bad clocks expected 0", mism); end
        checks++;
        if (rdc != 1) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 1", rdc); end
        checks++;
        if (cap_rd[nf] !== 1'b1) begin errors++; $display("FAIL b2b_rd_spacing: got %b at clock %0d expected 1", cap_rd[nf], nf + 1); end
        checks++;
        if (cap_tx[nf + 1 + 64 + 32 - 1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_data0: got %b expected 1", cap_tx[nf + 1 + 64 + 32 - 1]);
        end
    endtask

    task automatic test_gating();
        int nf, bad;
        nf = NBITS * 16;
        dvsr  = 11'd0;
        tx_en = 1'b0;
        @(posedge clk);
        #1;
        push(8'h5A);
        clear_cap();
        capture(100);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (cap_rd[i] !== 1'b0 || cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL gate_hold: got %0d bad clocks expected 0", bad); end
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        clear_cap();
        capture(2);
        checks++;
        if (cap_rd[0] !== 1'b1 || cap_tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL gate_pop: got rd=%b tx=%b expected rd=1 tx=1", cap_rd[0], cap_tx[0]);
        end
        checks++;
        if (cap_tx[1] !== 1'b0 || cap_rd[1] !== 1'b0) begin
            errors++;
            $display("FAIL gate_start_bit: got tx=%b rd=%b expected tx=0 rd=0", cap_tx[1], cap_rd[1]);
        end
        capture(nf);
        checks++;
        if (cap_busy[nf + 1] !== 1'b0 || fq.size() != 0) begin
            errors++;
            $display("FAIL gate_frame_done: got busy=%b fifo=%0d expected busy=0 fifo=0", cap_busy[nf + 1], fq.size());
        end
        clear_cap();
        capture(1000);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cap_rd[i] !== 1'b0 || cap_tx[i] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL gate_empty_no_pop: got %0d bad clocks expected 0", bad); end
    endtask

    task automatic test_reset_mid_frame();
        int nf, mism;
        bit found;
        nf = NBITS * 16;
        dvsr  = 11'd0;
        tx_en = 1'b1;
        @(posedge clk);
        #1;
        push(8'h3C);
        push(8'h81);
        wait_rd(20, found);
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_rd_seen: got 0 expected 1"); end
        repeat (40) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", tx_busy); end
        checks++;
        if (fifo_if.rd !== 1'b0 || fq.size() != 1) begin
            errors++;
            $display("FAIL rstmid_rd: got rd=%b fifo=%0d expected rd=0 fifo=1", fifo_if.rd, fq.size());
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_rd(10, found);
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_resume_rd: got 0 expected 1"); end
        clear_cap();
        capture(nf + 1);
        mism = 0;
        for (int i = 0; i <= nf; i++) begin
            if (cap_tx[i] !== frame_level(8'h81, i + 1, 16)) mism++;
        end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL rstmid_next_word: got %0d bad clocks expected 0", mism); end
    endtask

    task automatic test_divisor_change();
        int nf1, nf2, total, mism, rdc;
        bit found;
        nf1 = NBITS * 32;
        nf2 = NBITS * 128;
        total = nf1 + 1 + nf2 + 1;
        dvsr = 11'd1;
        @(posedge clk);
        #1;
        push(8'h96);
        push(8'h69);
        wait_rd(20, found);
        checks++;
        if (!found) begin errors++; $display("FAIL dvsr_rd_seen: got 0 expected 1"); end
        clear_cap();
        capture(100);
        dvsr = 11'd7;
        capture(total - 100);
        mism = 0; rdc = 0;
        for (int c = 1; c <= total; c++) begin
            logic e;
            if (c <= nf1) e = frame_level(8'h96, c, 32);
            else if (c == nf1 + 1) e = 1'b1;
            else e = frame_level(8'h69, c - nf1 - 1, 128);
            if (cap_tx[c-1] !== e) mism++;
            if (cap_rd[c-1] === 1'b1) rdc++;
        end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL dvsr_tx_pattern: got %0d bad clocks expected 0", mism); end
        checks++;
        if (rdc != 1 || cap_rd[nf1] !== 1'b1) begin
            errors++;
            $display("FAIL dvsr_rd_position: got count=%0d rd@gap=%b expected count=1 rd@gap=1", rdc, cap_rd[nf1]);
        end
        checks++;
        if (cap_busy[total - 1] !== 1'b0) begin errors++; $display("FAIL dvsr_end_idle: got %b expected 0", cap_busy[total - 1]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int nf, busy;
        bit found;
        nf = 176;
        dvsr = 11'd0;
        @(posedge clk);
        #1;
        push(8'h07);
        push(8'h03);
        wait_rd(20, found);
        checks++;
        if (!found) begin errors++; $display("FAIL par_rd_seen: got 0 expected 1"); end
        clear_cap();
        capture(2 * nf + 2);
        checks++;
        if (cap_tx[151] !== 1'b1) begin errors++; $display("FAIL par_bit_07: got %b expected 1", cap_tx[151]); end
        checks++;
        if (cap_tx[nf + 152] !== 1'b0) begin errors++; $display("FAIL par_bit_03: got %b expected 0", cap_tx[nf + 152]); end
        busy = 0;
        for (int i = 0; i <= nf; i++) begin
            if (cap_busy[i] === 1'b1) busy++;
        end
        checks++;
        if (busy != nf) begin errors++; $display("FAIL par_frame_len: got %0d expected %0d", busy, nf); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        tx_en = 1'b0;
        dvsr  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gating();
        test_reset_mid_frame();
        test_divisor_change();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
